// File: rtl/alu_writeback_pkg.sv
// Shared types and constants for the ALU writeback stage: FSM encoding,
// queued result entry layout and the flag-evaluation helper.
package alu_writeback_pkg;

   localparam int LEN_DATA      = 64;
   localparam int LEN_RADDR     = 5;
   localparam int WB_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      WB_IDLE  = 2'd0,
      WB_WR_LO = 2'd1,
      WB_WR_HI = 2'd2
   } wb_state_t;

   typedef struct packed {
      logic [LEN_DATA-1:0]  result;
      logic [LEN_DATA-1:0]  ex_result;
      logic [LEN_RADDR-1:0] rd;
      logic [LEN_RADDR-1:0] rd_ex;
      logic                 wide;
   } wb_entry_t;

   // Returns {zero, negative}; a wide result is zero only if both words are.
   function automatic logic [1:0] calc_zn(input logic [LEN_DATA-1:0] lo,
                                          input logic [LEN_DATA-1:0] hi,
                                          input logic                wide);
      logic z;
      logic n;
      z = (lo == '0) && (!wide || (hi == '0));
      n = wide ? hi[LEN_DATA-1] : lo[LEN_DATA-1];
      return {z, n};
   endfunction

endpackage

// File: rtl/alu_writeback_fifo.sv
// Synchronous result queue. The head entry and the address/data of the entry
// behind it are read straight from the storage flops.
module wb_fifo
   import alu_writeback_pkg::*;
#(
   parameter int DEPTH = WB_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  wb_entry_t                push_entry,
   output wb_entry_t                head,
   output logic [LEN_RADDR-1:0]     next_rd,
   output logic [LEN_DATA-1:0]      next_result,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_entry_t      mem [DEPTH];
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr_inc;
   logic           do_push;
   logic           do_pop;

   assign empty      = (count == '0);
   assign full       = (count == CW'(DEPTH));
   assign do_pop     = pop && !empty;
   // A pop in the same cycle frees the slot, so a full queue can still accept.
   assign do_push    = push && (!full || do_pop);
   assign rd_ptr_inc = rd_ptr + PW'(1);

   assign head        = mem[rd_ptr];
   assign next_rd     = mem[rd_ptr_inc].rd;
   assign next_result = mem[rd_ptr_inc].result;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr_inc;
         if (do_push && !do_pop)
            count <= count + CW'(1);
         else if (do_pop && !do_push)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_entry;
   end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback: captures results into a queue, keeps the C/Z/N flags and
// drains entries to the register file. Optional macro ALU_WB_BYPASS_EN adds
// a one-cycle bypass copy of each pushed low word.
module alu_writeback
   import alu_writeback_pkg::*;
#(
   parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_rdy,
   input  logic [LEN_DATA-1:0]  in_result,
   input  logic [LEN_DATA-1:0]  in_ex_result,
   input  logic                 in_cout,
   input  logic [LEN_RADDR-1:0] in_rd,
   input  logic [LEN_RADDR-1:0] in_rd_ex,
   input  logic                 in_wide,
   input  logic                 in_setf,
   output logic                 stall,
   output logic                 rf_we,
   output logic [LEN_RADDR-1:0] rf_waddr,
   output logic [LEN_DATA-1:0]  rf_wdata,
   input  logic                 rf_wack,
   output logic                 flag_c,
   output logic                 flag_z,
   output logic                 flag_n,
`ifdef ALU_WB_BYPASS_EN
   output logic                 byp_valid,
   output logic [LEN_RADDR-1:0] byp_addr,
   output logic [LEN_DATA-1:0]  byp_data,
`endif
   output logic                 ovf_err
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   wb_state_t            state_q;
   wb_state_t            state_d;
   wb_entry_t            push_entry;
   wb_entry_t            head;
   logic [LEN_RADDR-1:0] next_rd;
   logic [LEN_DATA-1:0]  next_result;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CW-1:0]        fifo_count;
   logic                 pop;
   logic                 push_ok;
   logic                 we_d;
   logic [LEN_RADDR-1:0] waddr_d;
   logic [LEN_DATA-1:0]  wdata_d;
   logic [1:0]           zn;

   assign push_entry = '{result:    in_result,
                         ex_result: in_ex_result,
                         rd:        in_rd,
                         rd_ex:     in_rd_ex,
                         wide:      in_wide};

   assign push_ok = in_rdy && (!fifo_full || pop);
   assign stall   = (fifo_count >= CW'(FIFO_DEPTH - 1));
   assign zn      = calc_zn(in_result, in_ex_result, in_wide);

   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (in_rdy),
      .pop         (pop),
      .push_entry  (push_entry),
      .head        (head),
      .next_rd     (next_rd),
      .next_result (next_result),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .count       (fifo_count)
   );

   // A word addressed to r0 is loaded with rf_we low, so its state completes
   // on the next cycle without waiting for an ack.
   always_comb begin
      state_d = state_q;
      we_d    = rf_we;
      waddr_d = rf_waddr;
      wdata_d = rf_wdata;
      pop     = 1'b0;
      case (state_q)
         WB_IDLE: begin
            if (!fifo_empty) begin
               state_d = WB_WR_LO;
               we_d    = (head.rd != '0);
               waddr_d = head.rd;
               wdata_d = head.result;
            end
         end
         WB_WR_LO, WB_WR_HI: begin
            if (!rf_we || rf_wack) begin
               if (state_q == WB_WR_LO && head.wide) begin
                  state_d = WB_WR_HI;
                  we_d    = (head.rd_ex != '0);
                  waddr_d = head.rd_ex;
                  wdata_d = head.ex_result;
               end else begin
                  pop = 1'b1;
                  // Load the following entry now so there is no idle bubble;
                  // with a single entry left, a same-cycle push is forwarded.
                  if (fifo_count >= CW'(2)) begin
                     state_d = WB_WR_LO;
                     we_d    = (next_rd != '0);
                     waddr_d = next_rd;
                     wdata_d = next_result;
                  end else if (in_rdy) begin
                     state_d = WB_WR_LO;
                     we_d    = (in_rd != '0);
                     waddr_d = in_rd;
                     wdata_d = in_result;
                  end else begin
                     state_d = WB_IDLE;
                     we_d    = 1'b0;
                     waddr_d = '0;
                     wdata_d = '0;
                  end
               end
            end
         end
         default: begin
            state_d = WB_IDLE;
            we_d    = 1'b0;
            waddr_d = '0;
            wdata_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= WB_IDLE;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         state_q  <= state_d;
         rf_we    <= we_d;
         rf_waddr <= waddr_d;
         rf_wdata <= wdata_d;
      end
   end

   // Flags follow only accepted pushes; a dropped result leaves them alone.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flag_c  <= 1'b0;
         flag_z  <= 1'b0;
         flag_n  <= 1'b0;
         ovf_err <= 1'b0;
      end else begin
         if (push_ok && in_setf) begin
            flag_c <= in_cout;
            flag_z <= zn[1];
            flag_n <= zn[0];
         end
         if (in_rdy && !push_ok)
            ovf_err <= 1'b1;
      end
   end

`ifdef ALU_WB_BYPASS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byp_valid <= 1'b0;
         byp_addr  <= '0;
         byp_data  <= '0;
      end else begin
         byp_valid <= push_ok && (in_rd != '0);
         if (push_ok) begin
            byp_addr <= in_rd;
            byp_data <= in_result;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback; bypass checks are compiled
// in when ALU_WB_BYPASS_EN is defined.
module tb_alu_writeback;
   import alu_writeback_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 in_rdy = 1'b0;
   logic [LEN_DATA-1:0]  in_result = '0;
   logic [LEN_DATA-1:0]  in_ex_result = '0;
   logic                 in_cout = 1'b0;
   logic [LEN_RADDR-1:0] in_rd = '0;
   logic [LEN_RADDR-1:0] in_rd_ex = '0;
   logic                 in_wide = 1'b0;
   logic                 in_setf = 1'b0;
   logic                 rf_wack = 1'b0;
   logic                 stall;
   logic                 rf_we;
   logic [LEN_RADDR-1:0] rf_waddr;
   logic [LEN_DATA-1:0]  rf_wdata;
   logic                 flag_c;
   logic                 flag_z;
   logic                 flag_n;
   logic                 ovf_err;
`ifdef ALU_WB_BYPASS_EN
   logic                 byp_valid;
   logic [LEN_RADDR-1:0] byp_addr;
   logic [LEN_DATA-1:0]  byp_data;
`endif

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   alu_writeback dut (
      .clk          (clk),
      .rst          (rst),
      .in_rdy       (in_rdy),
      .in_result    (in_result),
      .in_ex_result (in_ex_result),
      .in_cout      (in_cout),
      .in_rd        (in_rd),
      .in_rd_ex     (in_rd_ex),
      .in_wide      (in_wide),
      .in_setf      (in_setf),
      .stall        (stall),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .rf_wack      (rf_wack),
      .flag_c       (flag_c),
      .flag_z       (flag_z),
      .flag_n       (flag_n),
`ifdef ALU_WB_BYPASS_EN
      .byp_valid    (byp_valid),
      .byp_addr     (byp_addr),
      .byp_data     (byp_data),
`endif
      .ovf_err      (ovf_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rdy, input logic [LEN_DATA-1:0] res,
                        input logic [LEN_DATA-1:0] ex, input logic cout,
                        input logic [LEN_RADDR-1:0] rd, input logic [LEN_RADDR-1:0] rd_ex,
                        input logic wide, input logic setf);
      in_rdy = rdy; in_result = res; in_ex_result = ex; in_cout = cout;
      in_rd = rd; in_rd_ex = rd_ex; in_wide = wide; in_setf = setf;
   endtask

   task automatic idle_inputs();
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #2;
      rst = 1'b1;
      step();
   endtask

   task automatic test_reset();
      #1 rst = 1'b0;
      #3;
      checks++; if (rf_we !== 1'b0) begin fails++; $display("[TB] FAIL reset_we: got %0b expected 0", rf_we); end
      checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 64'd0) begin fails++; $display("[TB] FAIL reset_addr_data: got %0d/%h expected 0/0", rf_waddr, rf_wdata); end
      checks++; if ({flag_c, flag_z, flag_n} !== 3'b000) begin fails++; $display("[TB] FAIL reset_flags: got %b expected 000", {flag_c, flag_z, flag_n}); end
      checks++; if (stall !== 1'b0 || ovf_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_stall_ovf: got %b%b expected 00", stall, ovf_err); end
      @(negedge clk) rst = 1'b1;
      step();
   endtask

   task automatic test_narrow();
      rf_wack = 1'b1;
      drive(1'b1, 64'h8000_0000_0000_0000, '0, 1'b1, 5'd3, '0, 1'b0, 1'b1);
      step(); idle_inputs();
      checks++; if ({flag_c, flag_z, flag_n} !== 3'b101) begin fails++; $display("[TB] FAIL narrow_flags: got %b expected 101", {flag_c, flag_z, flag_n}); end
      checks++; if (rf_we !== 1'b0) begin fails++; $display("[TB] FAIL narrow_we_early: got %0b expected 0", rf_we); end
`ifdef ALU_WB_BYPASS_EN
      checks++; if (byp_valid !== 1'b1 || byp_addr !== 5'd3 || byp_data !== 64'h8000_0000_0000_0000) begin fails++; $display("[TB] FAIL narrow_byp: got %b/%0d/%h expected 1/3/8000000000000000", byp_valid, byp_addr, byp_data); end
`endif
      step();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 64'h8000_0000_0000_0000) begin fails++; $display("[TB] FAIL narrow_write: got %b/%0d/%h expected 1/3/8000000000000000", rf_we, rf_waddr, rf_wdata); end
`ifdef ALU_WB_BYPASS_EN
      checks++; if (byp_valid !== 1'b0) begin fails++; $display("[TB] FAIL narrow_byp_pulse: got %b expected 0", byp_valid); end
`endif
      step();
      checks++; if (rf_we !== 1'b0) begin fails++; $display("[TB] FAIL narrow_done: got %0b expected 0", rf_we); end
      rf_wack = 1'b0;
   endtask

   task automatic test_r0();
      drive(1'b1, '0, '0, 1'b0, 5'd0, '0, 1'b0, 1'b1);
      step(); idle_inputs();
      checks++; if ({flag_c, flag_z, flag_n} !== 3'b010) begin fails++; $display("[TB] FAIL r0_flags: got %b expected 010", {flag_c, flag_z, flag_n}); end
`ifdef ALU_WB_BYPASS_EN
      checks++; if (byp_valid !== 1'b0) begin fails++; $display("[TB] FAIL r0_byp: got %b expected 0", byp_valid); end
`endif
      checks++; if (rf_we !== 1'b0) begin fails++; $display("[TB] FAIL r0_we_c1: got %0b expected 0", rf_we); end
      step();
      checks++; if (rf_we !== 1'b0) begin fails++; $display("[TB] FAIL r0_we_c2: got %0b expected 0", rf_we); end
      step();
      checks++; if (rf_we !== 1'b0) begin fails++; $display("[TB] FAIL r0_we_c3: got %0b expected 0", rf_we); end
      rf_wack = 1'b1;
      drive(1'b1, 64'h77, '0, 1'b0, 5'd7, '0, 1'b0, 1'b0);
      step(); idle_inputs();
      step();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 64'h77) begin fails++; $display("[TB] FAIL r0_drained: got %b/%0d/%h expected 1/7/77", rf_we, rf_waddr, rf_wdata); end
      step();
      checks++; if (rf_we !== 1'b0) begin fails++; $display("[TB] FAIL r0_after: got %0b expected 0", rf_we); end
      rf_wack = 1'b0;
   endtask

   task automatic test_wide_r0();
      rf_wack = 1'b1;
      drive(1'b1, '0, 64'hF000_0000_0000_0ABC, 1'b0, 5'd0, 5'd9, 1'b1, 1'b1);
      step(); idle_inputs();
      checks++; if ({flag_c, flag_z, flag_n} !== 3'b001) begin fails++; $display("[TB] FAIL wide_r0_flags: got %b expected 001", {flag_c, flag_z, flag_n}); end
      step();
      checks++; if (rf_we !== 1'b0) begin fails++; $display("[TB] FAIL wide_r0_lo_skip: got %0b expected 0", rf_we); end
      step();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 64'hF000_0000_0000_0ABC) begin fails++; $display("[TB] FAIL wide_r0_hi: got %b/%0d/%h expected 1/9/f000000000000abc", rf_we, rf_waddr, rf_wdata); end
      step();
      checks++; if (rf_we !== 1'b0) begin fails++; $display("[TB] FAIL wide_r0_done: got %0b expected 0", rf_we); end
      rf_wack = 1'b0;
   endtask

   task automatic test_wide();
      rf_wack = 1'b0;
      drive(1'b1, '0, '0, 1'b0, 5'd4, 5'd5, 1'b1, 1'b1);
      step(); idle_inputs();
      checks++; if ({flag_c, flag_z, flag_n} !== 3'b010) begin fails++; $display("[TB] FAIL wide_flags: got %b expected 010", {flag_c, flag_z, flag_n}); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 64'd0) begin fails++; $display("[TB] FAIL wide_lo_hold%0d: got %b/%0d/%h expected 1/4/0", i, rf_we, rf_waddr, rf_wdata); end
      end
      rf_wack = 1'b1; step(); rf_wack = 1'b0;
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 64'd0) begin fails++; $display("[TB] FAIL wide_hi: got %b/%0d/%h expected 1/5/0", rf_we, rf_waddr, rf_wdata); end
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5) begin fails++; $display("[TB] FAIL wide_hi_hold%0d: got %b/%0d expected 1/5", i, rf_we, rf_waddr); end
      end
      rf_wack = 1'b1; step(); rf_wack = 1'b0;
      checks++; if (rf_we !== 1'b0) begin fails++; $display("[TB] FAIL wide_done: got %0b expected 0", rf_we); end
   endtask

   task automatic test_overflow();
      rf_wack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 64'(256 + i), '0, 1'b0, 5'(6 + i), '0, 1'b0, 1'b0);
         step();
         checks++; if (stall !== (i >= 2)) begin fails++; $display("[TB] FAIL ovf_stall%0d: got %b expected %b", i, stall, (i >= 2)); end
         checks++; if (ovf_err !== (i == 4)) begin fails++; $display("[TB] FAIL ovf_err%0d: got %b expected %b", i, ovf_err, (i == 4)); end
      end
      idle_inputs();
      rf_wack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'(6 + i) || rf_wdata !== 64'(256 + i)) begin fails++; $display("[TB] FAIL b2b_write%0d: got %b/%0d/%h expected 1/%0d/%h", i, rf_we, rf_waddr, rf_wdata, 6 + i, 256 + i); end
         step();
      end
      checks++; if (rf_we !== 1'b0 || stall !== 1'b0 || ovf_err !== 1'b1) begin fails++; $display("[TB] FAIL b2b_end: got we%b stall%b ovf%b expected we0 stall0 ovf1", rf_we, stall, ovf_err); end
      rf_wack = 1'b0;
   endtask

   task automatic test_full_push_pop();
      do_reset();
      rf_wack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 64'(1024 + i), '0, 1'b0, 5'(11 + i), '0, 1'b0, 1'b0);
         step();
      end
      checks++; if (stall !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd11) begin fails++; $display("[TB] FAIL full_before: got stall%b we%b addr%0d expected 1/1/11", stall, rf_we, rf_waddr); end
      drive(1'b1, 64'h500, '0, 1'b0, 5'd15, '0, 1'b0, 1'b0);
      rf_wack = 1'b1;
      step(); idle_inputs();
      checks++; if (ovf_err !== 1'b0 || stall !== 1'b1) begin fails++; $display("[TB] FAIL full_pushpop: got ovf%b stall%b expected 0/1", ovf_err, stall); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'(12 + i) || rf_wdata !== 64'(1025 + i)) begin fails++; $display("[TB] FAIL full_drain%0d: got %b/%0d/%h expected 1/%0d/%h", i, rf_we, rf_waddr, rf_wdata, 12 + i, 1025 + i); end
         step();
      end
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd15 || rf_wdata !== 64'h500) begin fails++; $display("[TB] FAIL full_accepted: got %b/%0d/%h expected 1/15/500", rf_we, rf_waddr, rf_wdata); end
      step();
      checks++; if (rf_we !== 1'b0 || ovf_err !== 1'b0) begin fails++; $display("[TB] FAIL full_end: got we%b ovf%b expected 0/0", rf_we, ovf_err); end
      rf_wack = 1'b0;
   endtask

   task automatic test_reset_mid();
      rf_wack = 1'b0;
      drive(1'b1, 64'd5, 64'd6, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1);
      step();
      drive(1'b1, 64'h33, '0, 1'b0, 5'd3, '0, 1'b0, 1'b0);
      step(); idle_inputs();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 64'd5) begin fails++; $display("[TB] FAIL mid_lo: got %b/%0d/%h expected 1/1/5", rf_we, rf_waddr, rf_wdata); end
      rf_wack = 1'b1; step(); rf_wack = 1'b0;
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 64'd6 || flag_c !== 1'b1) begin fails++; $display("[TB] FAIL mid_hi: got %b/%0d/%h c%b expected 1/2/6 c1", rf_we, rf_waddr, rf_wdata, flag_c); end
      #2 rst = 1'b0;
      #1;
      checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 64'd0) begin fails++; $display("[TB] FAIL mid_async_out: got %b/%0d/%h expected 0/0/0", rf_we, rf_waddr, rf_wdata); end
      checks++; if ({flag_c, flag_z, flag_n} !== 3'b000 || stall !== 1'b0) begin fails++; $display("[TB] FAIL mid_async_flags: got %b stall%b expected 000 stall0", {flag_c, flag_z, flag_n}, stall); end
      #2 rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (rf_we !== 1'b0) begin fails++; $display("[TB] FAIL mid_flushed%0d: got %0b expected 0", i, rf_we); end
      end
   endtask

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_narrow();
      test_r0();
      test_wide_r0();
      test_wide();
      test_overflow();
      test_full_push_pop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
